// File: rtl/exp_series_pkg.sv
// Shared types and widths for the exp(x) / exp(-x) Taylor-series evaluator.
package exp_series_pkg;

  // Width of the unsigned term register.
  localparam int TW   = 24;
  // Signed accumulator width. The two extra bits hold the sign and headroom.
  localparam int ACCW = TW + 2;
  // Width of the term index k. TERMS never exceeds 15, so 4 bits are enough.
  localparam int KW   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/exp_term_unit.sv
// Combinational term update: next_term = floor(term * x / k), unsigned and truncating.
module exp_term_unit
  import exp_series_pkg::*;
#(
  parameter int XW = 2
) (
  input  logic [TW-1:0] i_term,
  input  logic [XW-1:0] i_x,
  input  logic [KW-1:0] i_k,
  output logic [TW-1:0] o_term
);

  logic [TW+XW-1:0] w_prod;
  logic [TW+XW-1:0] w_div;

  assign w_prod = i_term * i_x;
  // k is zero only outside CAL, where the result is unused. A divisor of 1
  // keeps the divider defined in that case.
  assign w_div  = (i_k == '0) ? (TW+XW)'(1) : (TW+XW)'(i_k);
  assign o_term = TW'(w_prod / w_div);

endmodule

// File: rtl/exp_series.sv
// Iterative Taylor-series evaluator for exp(x) or exp(-x).
// Each partial sum is presented for one cycle and clamped to the output range.
module exp_series
  import exp_series_pkg::*;
#(
  parameter int XW    = 2,
  parameter int FRAC  = 5,
  parameter int TERMS = 11,
  parameter int OW    = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [XW-1:0] datain,
  input  logic          mode,
  input  logic          input_valid,
  output logic [OW-1:0] dataout,
  output logic          output_valid,
  output logic          busy,
  output logic          finish
);

  localparam logic [TW-1:0]          L_ONE_TERM = TW'(2 ** FRAC);
  localparam logic signed [ACCW-1:0] L_ONE_SUM  = ACCW'(2 ** FRAC);

  state_t                   r_state;
  logic [XW-1:0]            r_x;
  logic                     r_mode;
  logic [TW-1:0]            r_term;
  logic signed [ACCW-1:0]   r_sum;
  logic [KW-1:0]            r_k;
  logic [OW-1:0]            r_dataout;
  logic                     r_output_valid;
  logic                     r_busy;
  logic                     r_finish;

  logic [TW-1:0]            w_term_next;
  logic signed [ACCW-1:0]   w_term_ext;
  logic signed [ACCW-1:0]   w_sum_next;
  logic                     w_last;

  // Negative sums read as 0. Sums above 2^OW-1 saturate. The accumulator itself is never clamped.
  function automatic logic [OW-1:0] clamp_out(input logic signed [ACCW-1:0] s);
    if (s[ACCW-1]) begin
      return '0;
    end else if (|s[ACCW-2:OW]) begin
      return '1;
    end else begin
      return s[OW-1:0];
    end
  endfunction

  exp_term_unit #(
    .XW (XW)
  ) u_term (
    .i_term (r_term),
    .i_x    (r_x),
    .i_k    (r_k),
    .o_term (w_term_next)
  );

  // With mode=1 the series alternates sign: odd k subtracts the new term.
  assign w_term_ext = signed'({2'b00, w_term_next});
  assign w_sum_next = (r_mode && r_k[0]) ? (r_sum - w_term_ext) : (r_sum + w_term_ext);
  // The evaluation ends once the term budget is used up or the series has converged.
  assign w_last     = (r_k == KW'(TERMS)) || (r_term == '0);

  // Control FSM, term counter and accumulator. All outputs are registered.
  // NOTE: every sequential assignment is non-blocking, so all registers update
  // together from the values they held before the edge. This is also why
  // w_sum_next and clamp_out() both see the pre-edge r_sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_x            <= '0;
      r_mode         <= 1'b0;
      r_term         <= '0;
      r_sum          <= '0;
      r_k            <= '0;
      r_dataout      <= '0;
      r_output_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_finish       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (input_valid) begin
            r_x            <= datain;
            r_mode         <= mode;
            r_term         <= L_ONE_TERM;
            r_sum          <= L_ONE_SUM;
            r_k            <= KW'(1);
            r_dataout      <= clamp_out(L_ONE_SUM);
            r_output_valid <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= OUT;
          end
        end
        CAL: begin
          r_term         <= w_term_next;
          r_sum          <= w_sum_next;
          r_k            <= r_k + KW'(1);
          r_dataout      <= clamp_out(w_sum_next);
          r_output_valid <= 1'b1;
          r_state        <= OUT;
        end
        OUT: begin
          r_dataout      <= '0;
          r_output_valid <= 1'b0;
          if (w_last) begin
            r_finish <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_state  <= CAL;
          end
        end
        DONE: begin
          r_term   <= '0;
          r_sum    <= '0;
          r_k      <= '0;
          r_finish <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dataout      = r_dataout;
  assign output_valid = r_output_valid;
  assign busy         = r_busy;
  assign finish       = r_finish;

endmodule

// File: tb/tb_exp_series.sv
// Self-checking bench for exp_series: directed vectors, a held-request case,
// reset during an evaluation, and random operands against a series model.
module tb_exp_series;

  localparam int XW    = 2;
  localparam int FRAC  = 5;
  localparam int TERMS = 11;
  localparam int OW    = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [XW-1:0] datain = '0;
  logic          mode = 1'b0;
  logic          input_valid = 1'b0;
  logic [OW-1:0] dataout;
  logic          output_valid;
  logic          busy;
  logic          finish;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int m;
    int n;
    int exp_val[11];
  } vec_t;

  vec_t tbl[4];

  always #5 clk = ~clk;

  exp_series #(
    .XW    (XW),
    .FRAC  (FRAC),
    .TERMS (TERMS),
    .OW    (OW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .datain       (datain),
    .mode         (mode),
    .input_valid  (input_valid),
    .dataout      (dataout),
    .output_valid (output_valid),
    .busy         (busy),
    .finish       (finish)
  );

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Series reference written directly from the term and sum rules, using plain integers.
  task automatic model(input int x, input int m, output int q[$]);
    longint term, sum;
    int k;
    q.delete();
    term = longint'(1) << FRAC;
    sum  = term;
    k    = 1;
    q.push_back(clamp(sum));
    while (!(k == TERMS || term == 0)) begin
      term = (term * x) / k;
      if (m == 1 && (k % 2) == 1) sum = sum - term;
      else                        sum = sum + term;
      k++;
      q.push_back(clamp(sum));
    end
  endtask

  function automatic int clamp(input longint s);
    if (s < 0) return 0;
    if (s > (2 ** OW) - 1) return (2 ** OW) - 1;
    return int'(s);
  endfunction

  // Starts one evaluation and records every output, its cycle index and the finish cycle.
  task automatic run_eval(input int x, input int m, input bit hold,
                          output int got[$], output int cyc[$],
                          output int viol, output int fcyc);
    got.delete();
    cyc.delete();
    viol = 0;
    fcyc = -1;
    @(negedge clk);
    datain      = XW'(x);
    mode        = m[0];
    input_valid = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (!hold) input_valid = 1'b0;
      if (!busy) viol++;
      if (!output_valid && dataout != '0) viol++;
      if (output_valid) begin
        got.push_back(int'(dataout));
        cyc.push_back(c);
      end
      if (finish) begin
        if (output_valid) viol++;
        fcyc = c;
        break;
      end
    end
  endtask

  task automatic compare_seq(input string name, input int got[$], input int cyc[$],
                             input int viol, input int fcyc, input int exp_q[$]);
    int n;
    check({name, " count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s out[%0d]", name, i), got[i], exp_q[i]);
      check($sformatf("%s cycle[%0d]", name, i), cyc[i], 1 + 2 * i);
    end
    check({name, " finish cycle"}, fcyc, 2 * exp_q.size());
    check({name, " invariants"}, viol, 0);
  endtask

  task automatic do_eval(input string name, input int x, input int m, input int exp_q[$]);
    int got[$];
    int cyc[$];
    int viol, fcyc;
    run_eval(x, m, 1'b0, got, cyc, viol, fcyc);
    compare_seq(name, got, cyc, viol, fcyc, exp_q);
    @(negedge clk);
    check({name, " idle busy"}, int'(busy), 0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int got[$];
    int cyc[$];
    int viol, fcyc, n;
    bit seen;

    tbl[0] = '{x: 1, m: 0, n: 6,  exp_val: '{32, 64, 80, 85, 86, 86, 0, 0, 0, 0, 0}};
    tbl[1] = '{x: 1, m: 1, n: 6,  exp_val: '{32, 0, 16, 11, 12, 12, 0, 0, 0, 0, 0}};
    tbl[2] = '{x: 3, m: 0, n: 11, exp_val: '{32, 128, 272, 416, 524, 588, 620, 633, 637, 638, 638}};
    tbl[3] = '{x: 3, m: 1, n: 11, exp_val: '{32, 0, 80, 0, 44, 0, 12, 0, 3, 2, 2}};

    // Reset state
    #2;
    check("reset dataout", int'(dataout), 0);
    check("reset output_valid", int'(output_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset finish", int'(finish), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed vectors
    for (int t = 0; t < 4; t++) begin
      q.delete();
      for (int i = 0; i < tbl[t].n; i++) q.push_back(tbl[t].exp_val[i]);
      do_eval($sformatf("vec%0d x=%0d m=%0d", t, tbl[t].x, tbl[t].m), tbl[t].x, tbl[t].m, q);
    end

    // x=0 with input_valid held high through busy and DONE
    q.delete();
    q.push_back(32);
    q.push_back(32);
    run_eval(0, 0, 1'b1, got, cyc, viol, fcyc);
    compare_seq("hold x=0", got, cyc, viol, fcyc, q);
    @(negedge clk);
    check("hold idle after done", int'(busy), 0);
    check("hold no output in idle", int'(output_valid), 0);
    @(negedge clk);
    check("hold restart busy", int'(busy), 1);
    check("hold restart valid", int'(output_valid), 1);
    check("hold restart dataout", int'(dataout), 32);
    input_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (finish) begin
        seen = 1'b1;
        break;
      end
    end
    check("hold restart finish", int'(seen), 1);
    @(negedge clk);

    // Reset asserted during the 4th OUT of x=3
    @(negedge clk);
    datain      = XW'(3);
    mode        = 1'b0;
    input_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      input_valid = 1'b0;
      if (output_valid) n++;
      if (n == 4) break;
    end
    check("abort reached 4th out", n, 4);
    reset_n = 1'b0;
    #1;
    check("abort dataout", int'(dataout), 0);
    check("abort output_valid", int'(output_valid), 0);
    check("abort busy", int'(busy), 0);
    check("abort finish", int'(finish), 0);
    @(negedge clk);
    check("abort held busy", int'(busy), 0);
    reset_n = 1'b1;
    q.delete();
    for (int i = 0; i < tbl[0].n; i++) q.push_back(tbl[0].exp_val[i]);
    do_eval("after abort x=1 m=0", 1, 0, q);

    // Random operands against the model
    for (int r = 0; r < 20; r++) begin
      int rx, rm;
      rx = int'($urandom_range(0, (2 ** XW) - 1));
      rm = int'($urandom_range(0, 1));
      model(rx, rm, q);
      do_eval($sformatf("rand%0d x=%0d m=%0d", r, rx, rm), rx, rm, q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
